leta_cursor_tracker: RTL and testbench
======================================

# leta_cursor_tracker

Consumes the LETA trackball counter chip's 8-bit bus and turns raw wrapping counter values into clamped screen coordinates for two trackball cursors. It drives the LETA address lines and samples its data bus. Positions accumulate continuously and are republished once per frame on the vertical-sync edge, so the VGA pixel path sees values that stay stable for a whole frame. It replaces the ad-hoc two-channel address toggle in the top level and feeds the crosshair compare logic directly.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 128: GCLK cycles between changing `leta_ad` and sampling `leta_db`. Must exceed one LETA CK period (115 GCLK).
- `GAIN`, default 2: screen pixels per LETA count, applied to both axes.

Ports:
- `GCLK` in 1: single clock. Everything is synchronous to it.
- `reset` in 1: asynchronous, active-high reset.
- `leta_db` in 8: LETA data bus.
- `leta_ad` out 2: LETA channel address. Channel 0 = P0 col, 1 = P0 row, 2 = P1 col, 3 = P1 row.
- `vsync` in 1: VGA vertical sync, from the CLOCK_50 domain. Synchronized internally.
- `p0_col` out 10 and `p0_row` out 9: published cursor 0 position.
- `p1_col` out 10 and `p1_row` out 9: published cursor 1 position.
- `frame_strobe` out 1: one-cycle pulse when the published outputs update.

## Operation
- Round-robin FSM over channels 0→1→2→3→0. States:
  - ADDR: drive `leta_ad` = ch and clear the settle counter.
  - SETTLE: count to `SETTLE_CYCLES-1`.
  - SAMPLE: capture `leta_db`.
  - ACCUM: update the channel's working position, then advance ch and return to ADDR.
- Delta: `d = leta_db - prev[ch]`, computed mod 256 and read as signed 8-bit (range -128..+127). Then `prev[ch] <= leta_db`.
  - A counter wrap from 0xFF to 0x02 gives d = +3.
  - A wrap from 0x01 to 0xFE gives d = -3.
- Priming: the first SAMPLE of each channel after reset only loads `prev[ch]`, and d is forced to 0.
- Accumulate: `next = pos + d*GAIN`, computed at 12-bit signed width.
  - Clamp col to [0, 639] and row to [0, 479].
  - The clamp is saturating: further motion past an edge is discarded, and motion back away from the edge moves off it immediately.
- Publish:
  - On a rising edge of synchronized `vsync`, copy all four working positions to the outputs and pulse `frame_strobe`.
  - If the edge coincides with an ACCUM of some channel, the publish takes the pre-update working value. The update appears next frame.
- Reset values:
  - `leta_ad` = 0, FSM = ADDR, ch = 0.
  - All working and published cols = 320, rows = 240.
  - `prev` cleared, and every channel is marked unprimed.
  - `frame_strobe` = 0.
- Reset mid-sweep abandons the sweep immediately. Re-priming prevents a spurious jump afterwards.

## Timing
- Per-channel period is `SETTLE_CYCLES + 3` GCLK cycles: 131 at the default. A full sweep is 524 cycles.
- `leta_db` is sampled exactly `SETTLE_CYCLES + 1` cycles after `leta_ad` changes. `leta_ad` is registered and glitch-free.
- `vsync` uses a 2-flop synchronizer plus an edge register.
  - `frame_strobe` asserts 3 GCLK cycles after the `vsync` rising edge at the pin.
  - The outputs change in that same cycle.
- Outputs are held between strobes. There are no other output changes.

## Configuration
- `LETA_INVERT_ROW_EN`:
  - Defined: row deltas (channels 1 and 3) are negated before scaling, so upward ball motion moves the cursor up the screen.
  - Undefined: deltas are used as read.
  - Col channels are unaffected in both cases.

## Structure
- `leta_pkg` holds:
  - `SCREEN_W = 640`, `SCREEN_H = 480`, `CENTER_COL = 320`, `CENTER_ROW = 240`.
  - The FSM state enum (ADDR, SETTLE, SAMPLE, ACCUM).
  - The channel enum.
- Sub-module `leta_axis_accum`, one instance per channel. Parameter is LIMIT; inputs are sample strobe, db, and invert. It holds `prev`, the primed flag and the working position, and does the delta, clamp and saturate.
- The top FSM, settle counter and vsync publish logic live in `leta_cursor_tracker`.

## Test plan
- Reset, then hold `leta_db` = 0x40 on all channels for 2 sweeps and pulse `vsync` → outputs stay at col 320 / row 240, and `frame_strobe` is seen once.
- Ch0 steps 0x10→0x14, then publish → `p0_col` = 328 (+4×2); other outputs unchanged.
- Ch1 steps 0xFE→0x01 (wrap) → `p0_row` = 246. With `LETA_INVERT_ROW_EN` defined → 234.
- Ch2 increases +100 per sweep for 3 sweeps → `p1_col` saturates at 639. A following -5 step → 629.
- Assert `reset` during SETTLE of ch2, release, then apply a new `leta_db` = 0x90 → positions are back at center, and there is no jump on the first post-reset sample.
- Drive the `vsync` rising edge in the same cycle as a ch3 ACCUM → the published `p1_row` excludes that delta, and the next frame includes it.

Source files
------------

// File: rtl/leta_pkg.sv
// Shared screen geometry, FSM state and channel enums for the LETA cursor tracker.
package leta_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int CENTER_COL = 320;
    localparam int CENTER_ROW = 240;

    // Width of the signed accumulate/clamp arithmetic; holds pos + d*GAIN without overflow.
    localparam int ACC_W = 12;

    typedef enum logic [1:0] {
        ADDR,
        SETTLE,
        SAMPLE,
        ACCUM
    } state_e;

    typedef enum logic [1:0] {
        CH_P0_COL,
        CH_P0_ROW,
        CH_P1_COL,
        CH_P1_ROW
    } chan_e;

endpackage

// File: rtl/leta_cursor_tracker_if.sv
// LETA counter-chip bus: the tracker drives the channel address and reads the data bus.
interface leta_cursor_tracker_if;

    logic [1:0] leta_ad;
    logic [7:0] leta_db;

    modport master (output leta_ad, input leta_db);
    modport slave  (input leta_ad, output leta_db);

endinterface

// File: rtl/leta_axis_accum.sv
// One LETA axis: turns wrapping 8-bit counter samples into a saturating screen
// position in [0, LIMIT-1]. The first sample after reset only primes prev.
module leta_axis_accum
    import leta_pkg::*;
#(
    parameter int LIMIT  = SCREEN_W,
    parameter int CENTER = CENTER_COL,
    parameter int GAIN   = 2,
    parameter int W      = 10
) (
    input  logic         GCLK,
    input  logic         reset,
    input  logic         sample_i,
    input  logic [7:0]   db_i,
    input  logic         invert_i,
    output logic [W-1:0] pos_o
);

    logic [7:0]              prev_q, prev_d;
    logic                    primed_q, primed_d;
    logic [W-1:0]            pos_q, pos_d;
    logic signed [7:0]       delta8;
    logic signed [ACC_W-1:0] delta;
    logic signed [ACC_W-1:0] step;
    logic signed [ACC_W-1:0] next;

    // Modulo-256 difference read as signed gives the true motion across counter wraps.
    always_comb begin
        delta8   = signed'(db_i - prev_q);
        delta    = primed_q ? ACC_W'(delta8) : '0;
        if (invert_i) begin
            delta = -delta;
        end
        step     = delta * ACC_W'(GAIN);
        next     = signed'(ACC_W'(pos_q)) + step;
        pos_d    = pos_q;
        prev_d   = prev_q;
        primed_d = primed_q;
        if (sample_i) begin
            prev_d   = db_i;
            primed_d = 1'b1;
            if (next[ACC_W-1]) begin
                pos_d = '0;
            end else if (next > ACC_W'(LIMIT - 1)) begin
                pos_d = W'(LIMIT - 1);
            end else begin
                pos_d = next[W-1:0];
            end
        end
    end

    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            pos_q    <= W'(CENTER);
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            pos_q    <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/leta_cursor_tracker.sv
// Sweeps the four LETA channels round-robin and republishes both cursor positions
// on each synchronized vsync rising edge. Optional macro: LETA_INVERT_ROW_EN.
module leta_cursor_tracker
    import leta_pkg::*;
#(
    parameter int SETTLE_CYCLES = 128,
    parameter int GAIN          = 2
) (
    input  logic                  GCLK,
    input  logic                  reset,
    leta_cursor_tracker_if.master leta,
    input  logic                  vsync,
    output logic [9:0]            p0_col,
    output logic [8:0]            p0_row,
    output logic [9:0]            p1_col,
    output logic [8:0]            p1_row,
    output logic                  frame_strobe
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

`ifdef LETA_INVERT_ROW_EN
    localparam logic INVERT_ROWS = 1'b1;
`else
    localparam logic INVERT_ROWS = 1'b0;
`endif

    state_e           state_q;
    chan_e            ch_q;
    logic [CNT_W-1:0] settleCnt_q;
    logic [1:0]       ad_q;
    logic [7:0]       db_q;
    logic [3:0]       accum;

    logic [9:0]       p0ColPos, p1ColPos;
    logic [8:0]       p0RowPos, p1RowPos;
    logic [9:0]       p0Col_q, p1Col_q;
    logic [8:0]       p0Row_q, p1Row_q;
    logic [2:0]       vsyncSync_q;
    logic             vsyncRise;
    logic             frameStrobe_q;

    // The address only changes on leaving ADDR, so leta_db is sampled SETTLE_CYCLES+1 cycles later.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            state_q     <= ADDR;
            ch_q        <= CH_P0_COL;
            settleCnt_q <= '0;
            ad_q        <= '0;
            db_q        <= '0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    ad_q        <= ch_q;
                    settleCnt_q <= '0;
                    state_q     <= SETTLE;
                end
                SETTLE: begin
                    if (settleCnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= SAMPLE;
                    end else begin
                        settleCnt_q <= settleCnt_q + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    db_q    <= leta.leta_db;
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    ch_q    <= chan_e'(ch_q + 2'd1);
                    state_q <= ADDR;
                end
            endcase
        end
    end

    always_comb begin
        accum = '0;
        if (state_q == ACCUM) begin
            accum[ch_q] = 1'b1;
        end
    end

    assign leta.leta_ad = ad_q;

    leta_axis_accum #(.LIMIT(SCREEN_W), .CENTER(CENTER_COL), .GAIN(GAIN), .W(10)) uP0Col (
        .GCLK(GCLK), .reset(reset), .sample_i(accum[0]), .db_i(db_q),
        .invert_i(1'b0), .pos_o(p0ColPos));

    leta_axis_accum #(.LIMIT(SCREEN_H), .CENTER(CENTER_ROW), .GAIN(GAIN), .W(9)) uP0Row (
        .GCLK(GCLK), .reset(reset), .sample_i(accum[1]), .db_i(db_q),
        .invert_i(INVERT_ROWS), .pos_o(p0RowPos));

    leta_axis_accum #(.LIMIT(SCREEN_W), .CENTER(CENTER_COL), .GAIN(GAIN), .W(10)) uP1Col (
        .GCLK(GCLK), .reset(reset), .sample_i(accum[2]), .db_i(db_q),
        .invert_i(1'b0), .pos_o(p1ColPos));

    leta_axis_accum #(.LIMIT(SCREEN_H), .CENTER(CENTER_ROW), .GAIN(GAIN), .W(9)) uP1Row (
        .GCLK(GCLK), .reset(reset), .sample_i(accum[3]), .db_i(db_q),
        .invert_i(INVERT_ROWS), .pos_o(p1RowPos));

    assign vsyncRise = vsyncSync_q[1] & ~vsyncSync_q[2];

    // Publishing samples the working positions with <=, so a coincident ACCUM lands next frame.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            vsyncSync_q   <= '0;
            frameStrobe_q <= 1'b0;
            p0Col_q       <= 10'(CENTER_COL);
            p0Row_q       <= 9'(CENTER_ROW);
            p1Col_q       <= 10'(CENTER_COL);
            p1Row_q       <= 9'(CENTER_ROW);
        end else begin
            vsyncSync_q   <= {vsyncSync_q[1:0], vsync};
            frameStrobe_q <= vsyncRise;
            if (vsyncRise) begin
                p0Col_q <= p0ColPos;
                p0Row_q <= p0RowPos;
                p1Col_q <= p1ColPos;
                p1Row_q <= p1RowPos;
            end
        end
    end

    assign p0_col       = p0Col_q;
    assign p0_row       = p0Row_q;
    assign p1_col       = p1Col_q;
    assign p1_row       = p1Row_q;
    assign frame_strobe = frameStrobe_q;

endmodule

// File: tb/tb_leta_cursor_tracker.sv
// Scoreboard bench for leta_cursor_tracker: a LETA counter model feeds the bus,
// expected frames are queued at each vsync and checked when frame_strobe fires.
`timescale 1ns/1ps
module tb_leta_cursor_tracker;

    localparam int SETTLE     = 128;
    localparam int GAINV      = 2;
    localparam int SWEEP_WAIT = 600;

    typedef struct {
        int c0;
        int r0;
        int c1;
        int r1;
    } pubExp_t;

    logic       GCLK  = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic [9:0] p0_col, p1_col;
    logic [8:0] p0_row, p1_row;
    logic       frame_strobe;
    logic [7:0] counter [4];

    pubExp_t expQ[$];
    pubExp_t monExp;
    int      modelPos [4];
    int      lastOut [4];
    int      checks      = 0;
    int      errors      = 0;
    int      strobeCount = 0;

    leta_cursor_tracker_if lbus();

    // The LETA chip presents the counter selected by the address lines.
    assign lbus.leta_db = counter[lbus.leta_ad];

    always #5 GCLK = ~GCLK;

    leta_cursor_tracker #(.SETTLE_CYCLES(SETTLE), .GAIN(GAINV)) dut (
        .GCLK(GCLK),
        .reset(reset),
        .leta(lbus.master),
        .vsync(vsync),
        .p0_col(p0_col),
        .p0_row(p0_row),
        .p1_col(p1_col),
        .p1_row(p1_row),
        .frame_strobe(frame_strobe)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        modelPos[0] = 320;
        modelPos[1] = 240;
        modelPos[2] = 320;
        modelPos[3] = 240;
    endfunction

    // Cursor moves GAIN pixels per count of true ball motion, pinned inside the screen.
    function automatic void modelStep(input int ch, input int delta);
        int d;
        int limit;
        int p;
        d     = delta;
        limit = (ch % 2 == 1) ? 480 : 640;
`ifdef LETA_INVERT_ROW_EN
        if (ch % 2 == 1) d = -d;
`endif
        p = modelPos[ch] + d * GAINV;
        if (p < 0) p = 0;
        if (p > limit - 1) p = limit - 1;
        modelPos[ch] = p;
    endfunction

    // Moves the ball on one channel by a signed amount in -128..127.
    task automatic applyStimulus(input int ch, input int delta);
        counter[ch] = counter[ch] + 8'(delta);
        modelStep(ch, delta);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge GCLK);
        #1;
    endtask

    task automatic doReset(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
        @(posedge GCLK);
        #1 reset = 1'b1;
        counter[0] = c0;
        counter[1] = c1;
        counter[2] = c2;
        counter[3] = c3;
        expQ.delete();
        modelReset();
        waitCycles(3);
        checkOutput("reset_leta_ad", int'(lbus.leta_ad), 0);
        checkOutput("reset_strobe", int'(frame_strobe), 0);
        checkOutput("reset_p0_col", int'(p0_col), 320);
        checkOutput("reset_p0_row", int'(p0_row), 240);
        checkOutput("reset_p1_col", int'(p1_col), 320);
        checkOutput("reset_p1_row", int'(p1_row), 240);
        reset = 1'b0;
    endtask

    task automatic strobeLatency();
        repeat (3) @(posedge GCLK);
        #1;
        checkOutput("strobe_latency", int'(frame_strobe), 1);
        vsync = 1'b0;
        waitCycles(4);
    endtask

    task automatic publish();
        expQ.push_back('{modelPos[0], modelPos[1], modelPos[2], modelPos[3]});
        @(posedge GCLK);
        #1 vsync = 1'b1;
        strobeLatency();
    endtask

    task automatic waitAd(input logic [1:0] target);
        int n;
        n = 0;
        while (lbus.leta_ad == target && n < 2000) begin
            waitCycles(1);
            n++;
        end
        while (lbus.leta_ad != target && n < 2000) begin
            waitCycles(1);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_leta_ad: address %0d not reached, required within 2000 cycles", target);
        end
    endtask

    // Monitor: pops one expected frame per strobe and flags any output change between strobes.
    always @(negedge GCLK) begin
        if (reset) begin
            lastOut = '{int'(p0_col), int'(p0_row), int'(p1_col), int'(p1_row)};
        end else if (frame_strobe) begin
            strobeCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL strobe_unexpected: got frame_strobe, expected none");
            end else begin
                monExp = expQ.pop_front();
                checkOutput("p0_col", int'(p0_col), monExp.c0);
                checkOutput("p0_row", int'(p0_row), monExp.r0);
                checkOutput("p1_col", int'(p1_col), monExp.c1);
                checkOutput("p1_row", int'(p1_row), monExp.r1);
            end
            lastOut = '{int'(p0_col), int'(p0_row), int'(p1_col), int'(p1_row)};
        end else if (int'(p0_col) != lastOut[0] || int'(p0_row) != lastOut[1] ||
                     int'(p1_col) != lastOut[2] || int'(p1_row) != lastOut[3]) begin
            checks++;
            errors++;
            $display("[TB] FAIL output_hold: got %0d/%0d/%0d/%0d without strobe, expected %0d/%0d/%0d/%0d",
                     p0_col, p0_row, p1_col, p1_row, lastOut[0], lastOut[1], lastOut[2], lastOut[3]);
            lastOut = '{int'(p0_col), int'(p0_row), int'(p1_col), int'(p1_row)};
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: simulation still running at 3 ms, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int strobesBefore;
        int nSteps;

        modelReset();
        counter = '{8'h40, 8'h40, 8'h40, 8'h40};

        // Idle counters: nothing moves, one strobe per vsync.
        doReset(8'h40, 8'h40, 8'h40, 8'h40);
        waitCycles(2 * SWEEP_WAIT);
        strobesBefore = strobeCount;
        publish();
        checkOutput("idle_strobe_count", strobeCount - strobesBefore, 1);

        // Small step on P0 col and a wrapping step on P0 row.
        doReset(8'h10, 8'hFE, 8'h40, 8'h40);
        waitCycles(SWEEP_WAIT);
        applyStimulus(0, 4);
        applyStimulus(1, 3);
        waitCycles(SWEEP_WAIT);
        publish();

        // Drive P1 col into the right edge, then back off it.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 100);
            waitCycles(SWEEP_WAIT);
        end
        publish();
        applyStimulus(2, -5);
        waitCycles(SWEEP_WAIT);
        publish();

        // Reset in the middle of the ch2 settle; new counter values must not cause a jump.
        waitAd(2'd2);
        waitCycles(20);
        doReset(8'h90, 8'h90, 8'h90, 8'h90);
        waitCycles(SWEEP_WAIT);
        publish();

        // vsync edge timed so the publish lands on the ch3 ACCUM cycle.
        applyStimulus(3, 5);
        waitCycles(SWEEP_WAIT);
        publish();
        waitAd(2'd3);
        counter[3] = counter[3] + 8'd7;
        expQ.push_back('{modelPos[0], modelPos[1], modelPos[2], modelPos[3]});
        repeat (SETTLE - 1) @(posedge GCLK);
        #1 vsync = 1'b1;
        strobeLatency();
        modelStep(3, 7);
        waitCycles(SWEEP_WAIT);
        publish();

        // Random ball motion, sometimes several steps per frame.
        for (int round = 0; round < 12; round++) begin
            nSteps = int'($urandom_range(1, 3));
            for (int s = 0; s < nSteps; s++) begin
                for (int ch = 0; ch < 4; ch++) begin
                    if ($urandom_range(0, 3) != 0) begin
                        applyStimulus(ch, int'($urandom_range(0, 255)) - 128);
                    end
                end
                waitCycles(SWEEP_WAIT);
            end
            publish();
        end

        waitCycles(10);
        checkOutput("pending_publishes", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
